// File: rtl/system_sysid_reader.sv
// Avalon-MM master that reads sysid word 0 (ID) and word 1 (timestamp) once per
// start pulse and compares them against expected values, with a per-read timeout.
module system_sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1456093976,
  parameter int unsigned TIMEOUT_CYCLES     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_FIN
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        at_limit;

  assign at_limit = (cnt_q == LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RD_ID;
          cnt_d      = '0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
        end
      end
      // An acceptance on the limit cycle still leaves the data outstanding, so it times out.
      S_RD_ID, S_RD_TS: begin
        cnt_d = cnt_q + 16'd1;
        if (at_limit) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else if (!avm_waitrequest) begin
          state_d = (state_q == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
        end
      end
      S_WAIT_ID: begin
        cnt_d = cnt_q + 16'd1;
        if (avm_readdatavalid) begin
          id_value_d = avm_readdata;
          id_match_d = (avm_readdata == EXPECTED_ID);
          cnt_d      = '0;
          state_d    = S_RD_TS;
        end else if (at_limit) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_WAIT_TS: begin
        cnt_d = cnt_q + 16'd1;
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          ts_match_d = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d    = S_FIN;
        end else if (at_limit) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign avm_address = (state_q == S_RD_TS);
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_system_sysid_reader.sv
// Directed bench for system_sysid_reader: two instances (default and 4-cycle timeout)
// share scripted slave inputs and are checked every cycle against a timeline model.
module tb_system_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1456093976;
  localparam int NC = 100;

  typedef struct {
    int fin, r0s, r0e, r1s, r1e, vid, vts;
    bit to;
  } res_t;

  logic        clock = 1'b0;
  logic        reset, start, wr, vl;
  logic [31:0] dt;

  logic        busy0, done0, rd0, ad0, idm0, tsm0, to0;
  logic [31:0] idv0, tsv0;
  logic        busy1, done1, rd1, ad1, idm1, tsm1, to1;
  logic [31:0] idv1, tsv1;

  logic [70:0] act [2];
  logic [70:0] expv [2];
  logic [70:0] prev [2];
  int          done_cyc [2];
  int          cur_c;
  bit          chk_en;
  int          checks, failures;

  bit          wr_s [NC];
  bit          vl_s [NC];
  bit          st_s [NC];
  logic [31:0] dt_s [NC];

  always #5 clock = ~clock;

  system_sysid_reader dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(ad0), .avm_read(rd0), .avm_waitrequest(wr),
    .avm_readdatavalid(vl), .avm_readdata(dt),
    .busy(busy0), .done(done0), .id_match(idm0), .ts_match(tsm0),
    .timeout(to0), .id_value(idv0), .ts_value(tsv0)
  );

  system_sysid_reader #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(ad1), .avm_read(rd1), .avm_waitrequest(wr),
    .avm_readdatavalid(vl), .avm_readdata(dt),
    .busy(busy1), .done(done1), .id_match(idm1), .ts_match(tsm1),
    .timeout(to1), .id_value(idv1), .ts_value(tsv1)
  );

  assign act[0] = {busy0, done0, rd0, ad0, idm0, tsm0, to0, idv0, tsv0};
  assign act[1] = {busy1, done1, rd1, ad1, idm1, tsm1, to1, idv1, tsv1};

  // Outcome of one sequence from the slave script: cycle 1 is the first cycle of the
  // ID read, each word gets T cycles from its own read start.
  function automatic res_t model(int T);
    res_t r;
    int t, a, v, lim;
    r.r0s = 1; r.r0e = 0; r.r1s = -1; r.r1e = -2;
    r.vid = -1; r.vts = -1; r.to = 0; r.fin = 0;
    t = 1;
    for (int w = 0; w < 2; w++) begin
      lim = t + T - 1;
      if (w == 1) r.r1s = t;
      a = t;
      while (a < NC - 1 && wr_s[a]) a++;
      if (a >= lim) begin
        if (w == 0) r.r0e = lim; else r.r1e = lim;
        r.to = 1; r.fin = lim + 1;
        return r;
      end
      if (w == 0) r.r0e = a; else r.r1e = a;
      v = a + 1;
      while (v < NC - 1 && !vl_s[v]) v++;
      if (v > lim) begin
        r.to = 1; r.fin = lim + 1;
        return r;
      end
      if (w == 0) r.vid = v; else r.vts = v;
      t = v + 1;
    end
    r.fin = t;
    return r;
  endfunction

  function automatic logic [70:0] exp_out(res_t r, int c, logic [70:0] pv);
    logic b, d, rd, ad, im, tm, to;
    logic [31:0] iv, tv;
    if (c == 0) return {4'b0, pv[66:0]};
    b  = (c <= r.fin);
    d  = (c == r.fin);
    ad = (c >= r.r1s) && (c <= r.r1e);
    rd = ((c >= r.r0s) && (c <= r.r0e)) || ad;
    iv = (r.vid >= 0 && c > r.vid) ? dt_s[r.vid] : 32'd0;
    tv = (r.vts >= 0 && c > r.vts) ? dt_s[r.vts] : 32'd0;
    im = (r.vid >= 0 && c > r.vid) && (dt_s[r.vid] == EXP_ID);
    tm = (r.vts >= 0 && c > r.vts) && (dt_s[r.vts] == EXP_TS);
    to = r.to && (c >= r.fin);
    return {b, d, rd, ad, im, tm, to, iv, tv};
  endfunction

  task automatic chk(string nm, logic [70:0] a, logic [70:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic clear_script();
    for (int i = 0; i < NC; i++) begin
      wr_s[i] = 1'b0; vl_s[i] = 1'b0; st_s[i] = 1'b0;
      dt_s[i] = 32'hA5A5_0000 | 32'(i);
    end
  endtask

  task automatic run_test();
    res_t r [2];
    int n;
    r[0] = model(64);
    r[1] = model(4);
    n = ((r[0].fin > r[1].fin) ? r[0].fin : r[1].fin) + 3;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      start = (c == 0) || st_s[c];
      wr = wr_s[c]; vl = vl_s[c]; dt = dt_s[c];
      for (int k = 0; k < 2; k++) expv[k] = exp_out(r[k], c, prev[k]);
      cur_c  = c;
      chk_en = 1'b1;
    end
    @(negedge clock); #1;
    start = 1'b0;
    prev[0] = expv[0];
    prev[1] = expv[1];
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (act[k] !== expv[k]) begin
            failures++;
            $display("FAIL cycle_cmp dut%0d c=%0d: got %h expected %h", k, cur_c, act[k], expv[k]);
          end
          if (act[k][69] === 1'b1 && done_cyc[k] < 0) done_cyc[k] = cur_c;
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0; cur_c = 0;
    reset = 1'b1; start = 1'b0; wr = 1'b0; vl = 1'b0; dt = '0;
    prev[0] = '0; prev[1] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state0", act[0], 71'd0);
    chk("reset_state1", act[1], 71'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Nominal: no stall, latency 1
    clear_script();
    vl_s[2] = 1'b1; dt_s[2] = EXP_ID;
    vl_s[4] = 1'b1; dt_s[4] = EXP_TS;
    run_test();
    chk("nominal_done_cycle", 71'(done_cyc[0]), 71'd5);
    chk("nominal_flags", {idm0, tsm0, to0}, 3'b110);
    chk("nominal_t4_done_cycle", 71'(done_cyc[1]), 71'd5);

    // Wrong ID, timestamp still read
    clear_script();
    vl_s[2] = 1'b1; dt_s[2] = 32'd7;
    vl_s[4] = 1'b1; dt_s[4] = EXP_TS;
    run_test();
    chk("bad_id_value", idv0, 32'd7);
    chk("bad_id_flags", {idm0, tsm0, to0}, 3'b010);

    // Three waitrequest cycles per read; the 4-cycle instance times out on word 0
    clear_script();
    for (int i = 1; i <= 3; i++) wr_s[i] = 1'b1;
    vl_s[5] = 1'b1; dt_s[5] = EXP_ID;
    for (int i = 6; i <= 8; i++) wr_s[i] = 1'b1;
    vl_s[10] = 1'b1; dt_s[10] = EXP_TS;
    run_test();
    chk("stall_done_cycle", 71'(done_cyc[0]), 71'd11);
    chk("stall_flags", {idm0, tsm0, to0}, 3'b110);
    chk("stall_t4_done_cycle", 71'(done_cyc[1]), 71'd5);
    chk("stall_t4_flags", {idm1, tsm1, to1}, 3'b001);

    // Timestamp never returned
    clear_script();
    vl_s[2] = 1'b1; dt_s[2] = EXP_ID;
    run_test();
    chk("ts_lost_t4_done_cycle", 71'(done_cyc[1]), 71'd7);
    chk("ts_lost_t4_flags", {idm1, tsm1, to1}, 3'b101);
    chk("ts_lost_done_cycle", 71'(done_cyc[0]), 71'd67);

    // Data on the limit cycle, stray valids, and start pulses while busy
    clear_script();
    wr_s[1] = 1'b1; wr_s[2] = 1'b1;
    vl_s[1] = 1'b1; vl_s[3] = 1'b1;
    vl_s[4] = 1'b1; dt_s[4] = EXP_ID;
    vl_s[8] = 1'b1; dt_s[8] = EXP_TS;
    st_s[3] = 1'b1; st_s[9] = 1'b1;
    run_test();
    chk("limit_t4_done_cycle", 71'(done_cyc[1]), 71'd9);
    chk("limit_t4_flags", {idm1, tsm1, to1}, 3'b110);
    chk("limit_t4_ts_value", tsv1, EXP_TS);

    // Reset while waiting for the ID, then a late response
    chk_en = 1'b0;
    @(posedge clock); #1; start = 1'b1; wr = 1'b0; vl = 1'b0;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_busy0", 71'(act[0][70]), 71'd1);
    chk("rst_mid_busy1", 71'(act[1][70]), 71'd1);
    @(posedge clock); #1; reset = 1'b0; vl = 1'b1; dt = EXP_ID;
    @(negedge clock);
    chk("rst_after0", act[0], 71'd0);
    chk("rst_after1", act[1], 71'd0);
    @(posedge clock); #1; vl = 1'b0;
    @(negedge clock);
    chk("rst_late_valid0", act[0], 71'd0);
    chk("rst_late_valid1", act[1], 71'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/system_sysid_reader.md
SYSTEM_SYSID_READER -- requirements
Module: system_sysid_reader

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 0, meaning the 32-bit value expected at sysid word 0 (system ID).
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 1456093976, meaning the 32-bit value expected at sysid word 1 (build timestamp).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, range 2..65535, meaning the per-transaction cycle limit before abort.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to run one check sequence.
REQ-007 SHALL have port avm_address, output, 1, Avalon-MM word address toward the sysid slave.
REQ-008 SHALL have port avm_read, output, 1, Avalon-MM read strobe.
REQ-009 SHALL have port avm_waitrequest, input, 1, slave stall; read accepted in a cycle where avm_read=1 and avm_waitrequest=0.
REQ-010 SHALL have port avm_readdatavalid, input, 1, qualifies avm_readdata.
REQ-011 SHALL have port avm_readdata, input, 32, read response data.
REQ-012 SHALL have ports busy (1), done (1), id_match (1), ts_match (1), timeout (1), all outputs, status flags.
REQ-013 SHALL have ports id_value (32) and ts_value (32), outputs, captured read data.

Function
REQ-014 SHALL implement states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, FIN.
REQ-015 IDLE: start=1 SHALL move to RD_ID next cycle, clear id_match, ts_match, timeout, id_value, ts_value; start SHALL be ignored in all other states.
REQ-016 RD_ID: avm_read=1, avm_address=0; on acceptance SHALL move to WAIT_ID; avm_address/avm_read SHALL stay stable while avm_waitrequest=1.
REQ-017 WAIT_ID: avm_read=0; on avm_readdatavalid=1 SHALL capture id_value, set id_match=(avm_readdata==EXPECTED_ID), move to RD_TS.
REQ-018 RD_TS/WAIT_TS SHALL mirror RD_ID/WAIT_ID with avm_address=1, capturing ts_value and ts_match, then move to FIN.
REQ-019 avm_readdatavalid SHALL be ignored outside WAIT_ID/WAIT_TS, including the acceptance cycle itself (minimum read latency 1).
REQ-020 Timeout counter SHALL clear on entry to RD_ID and to RD_TS and increment every cycle spent in the RD/WAIT pair.
REQ-021 When the counter equals TIMEOUT_CYCLES-1 and the current cycle does not complete the read (valid data in WAIT_x), SHALL set timeout=1, deassert avm_read, move to FIN; the unread word's match flag stays 0.
REQ-022 Data arriving in the same cycle the limit is reached SHALL count as success (completion wins over timeout).
REQ-023 FIN: done=1 for exactly one cycle, then IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 id_match, ts_match, timeout, id_value, ts_value SHALL hold their values from FIN until the next accepted start or reset.
REQ-026 Minimum sequence with zero waitrequest and latency 1: start at cycle 0 -> done=1 at cycle 5.
REQ-027 avm_address SHALL be 0 whenever avm_read=0.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE and zero every output (busy, done, avm_read, avm_address, flags, id_value, ts_value) and the timeout counter.
REQ-029 reset asserted mid-sequence SHALL drop avm_read on the next edge; responses arriving afterwards SHALL be ignored.

Verification
REQ-030 Slave returns 0 at word 0, 1456093976 at word 1, no stall, latency 1; start pulse -> done at cycle 5, id_match=1, ts_match=1, timeout=0.
REQ-031 Slave returns 7 at word 0 -> id_value=7, id_match=0; timestamp still read, ts_match=1.
REQ-032 avm_waitrequest held high 3 cycles on each read -> avm_read/avm_address stable throughout, done at cycle 11, both matches 1.
REQ-033 TIMEOUT_CYCLES=4, avm_readdatavalid never asserted on word 1 -> timeout=1, id_match=1, ts_match=0, done one cycle after 4th cycle in RD_TS/WAIT_TS.
REQ-034 Data valid exactly on the limit cycle -> timeout=0, value captured; start pulsed while busy -> no effect.
REQ-035 reset during WAIT_ID, then late readdatavalid -> all outputs 0, state IDLE, id_value remains 0.
